func1_down_compress_stage: RTL

//  Register-and-compress stage directly downstream of the Func1 "down" coordinate functions (2nd-order, 3-share inversion).

---
 rtl/func1_down_compress_stage.sv | 101 ++++++++++
 1 files changed

// File: rtl/func1_down_compress_stage.sv
// Register-and-compress stage behind the Func1 "down" coordinate functions.
// It owns the fresh-randomness register and registers the 9 shares per coordinate, then XOR-folds them to 3 shares.
module func1_down_compress_stage #(
    parameter int COORDS           = 2,
    parameter bit CLEAR_ON_CONSUME = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            rnd_in,
    input  logic                  rnd_valid,
    output logic                  rnd_ready,
    output logic [5:0]            r_out,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [9*COORDS-1:0]   q_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [COORDS-1:0]     y1,
    output logic [COORDS-1:0]     y2,
    output logic [COORDS-1:0]     y3
);

    logic [5:0]          r_reg;
    logic                r_full;
    logic [9*COORDS-1:0] s1_q;
    logic                s1_v;

    logic s2_take;
    logic s1_free;
    logic in_fire;
    logic r_load;

    logic [COORDS-1:0] fold1;
    logic [COORDS-1:0] fold2;
    logic [COORDS-1:0] fold3;

    assign s2_take   = s1_v & (~out_valid | out_ready);
    assign s1_free   = ~s1_v | s2_take;
    assign in_ready  = r_full & s1_free;
    assign in_fire   = in_valid & in_ready;
    assign rnd_ready = ~r_full | in_fire;
    assign r_load    = rnd_valid & rnd_ready;
    assign r_out     = r_reg;

    // r_reg may only change on a consume or a load, so r_out stays stable for the upstream logic between transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg  <= '0;
            r_full <= 1'b0;
        end else if (r_load) begin
            r_reg  <= rnd_in;
            r_full <= 1'b1;
        end else if (in_fire) begin
            r_full <= 1'b0;
            if (CLEAR_ON_CONSUME) begin
                r_reg <= '0;
            end
        end
    end

    // Plain register on the uncompressed shares: a glitch barrier, so no logic may sit in front of these flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s1_v <= 1'b0;
        end else if (in_fire) begin
            s1_q <= q_in;
            s1_v <= 1'b1;
        end else if (s2_take) begin
            s1_v <= 1'b0;
        end
    end

    always_comb begin
        fold1 = '0;
        fold2 = '0;
        fold3 = '0;
        for (int j = 0; j < COORDS; j++) begin
            fold1[j] = ^s1_q[9*j +: 3];
            fold2[j] = ^s1_q[9*j+3 +: 3];
            fold3[j] = ^s1_q[9*j+6 +: 3];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y1        <= '0;
            y2        <= '0;
            y3        <= '0;
            out_valid <= 1'b0;
        end else begin
            if (s2_take) begin
                y1 <= fold1;
                y2 <= fold2;
                y3 <= fold3;
            end
            out_valid <= s2_take | (out_valid & ~out_ready);
        end
    end

endmodule
